cr_lz77_comp_sym_ser: RTL and testbench

CR_LZ77_COMP_SYM_SER -- requirements
Module: cr_lz77_comp_sym_ser

---
 rtl/cr_lz77_comp_sym_ser_if.sv | 54 +++++
 rtl/cr_lz77_comp_sym_ser.sv | 158 +++++++++++++++
 tb/tb_cr_lz77_comp_sym_ser.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cr_lz77_comp_sym_ser_if.sv
`default_nettype none
// ============================================================================
// Module      : cr_lz77_comp_sym_ser_if
// Description : Beat input and symbol output bundle for the LZ77 symbol
//               serializer. The slave modport is the serializer side; the
//               master modport is the environment side (beat source and
//               symbol sink). The stats counters exist only when
//               CR_LZ77_COMP_SYM_SER_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface cr_lz77_comp_sym_ser_if #(
    parameter int LEN_W = 10
);
    logic [4:0][1:0]  me_output_type;
    logic [3:0][7:0]  me_literal;
    logic [LEN_W-1:0] me_ptr_length;
    logic [LEN_W-1:0] me_ptr_offset;
    logic             me_last_output;

    logic             ser_valid;
    logic             ser_ready;
    logic [1:0]       ser_type;
    logic [7:0]       ser_literal;
    logic [LEN_W-1:0] ser_ptr_length;
    logic [LEN_W-1:0] ser_ptr_offset;
    logic             ser_last;
    logic             ser_afull;
    logic             ser_overflow;
`ifdef CR_LZ77_COMP_SYM_SER_STATS_EN
    logic [31:0]      ser_lit_count;
    logic [31:0]      ser_ptr_count;
`endif

    modport slave (
        input  me_output_type, me_literal, me_ptr_length, me_ptr_offset,
               me_last_output, ser_ready,
        output ser_valid, ser_type, ser_literal, ser_ptr_length,
               ser_ptr_offset, ser_last, ser_afull, ser_overflow
`ifdef CR_LZ77_COMP_SYM_SER_STATS_EN
        , output ser_lit_count, ser_ptr_count
`endif
    );

    modport master (
        output me_output_type, me_literal, me_ptr_length, me_ptr_offset,
               me_last_output, ser_ready,
        input  ser_valid, ser_type, ser_literal, ser_ptr_length,
               ser_ptr_offset, ser_last, ser_afull, ser_overflow
`ifdef CR_LZ77_COMP_SYM_SER_STATS_EN
        , input ser_lit_count, ser_ptr_count
`endif
    );
endinterface
`default_nettype wire

// File: rtl/cr_lz77_comp_sym_ser.sv
`default_nettype none
// ============================================================================
// Module      : cr_lz77_comp_sym_ser
// Description : Queues LZ77 match-engine beats (up to five symbols each) in a
//               FIFO and presents them one symbol per valid/ready handshake.
//               Optional macro CR_LZ77_COMP_SYM_SER_STATS_EN adds saturating
//               LIT and PTR/MTF handshake counters.
//               LEN_W must match the LEN_W of the connected interface.
// Revision    : 1.0 - initial release
// ============================================================================
module cr_lz77_comp_sym_ser #(
    parameter int LEN_W = 10,
    parameter int DEPTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    cr_lz77_comp_sym_ser_if.slave bus
);
    localparam int         AW        = $clog2(DEPTH);
    localparam logic [1:0] T_NULL    = 2'd0;
    localparam logic [1:0] T_LIT     = 2'd1;
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_CNT = (AW+1)'(DEPTH - 2);

    // Beat storage; contents only matter below the occupancy count, so no reset.
    logic [4:0][1:0]  mem_type [DEPTH];
    logic [3:0][7:0]  mem_lit  [DEPTH];
    logic [LEN_W-1:0] mem_len  [DEPTH];
    logic [LEN_W-1:0] mem_off  [DEPTH];
    logic             mem_last [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [2:0]    idx;        // first slot of the head beat not yet presented
    logic [1:0]    lidx;       // LIT ordinal within the head beat
    logic          overflow;

    logic [4:0][1:0] head_type;
    logic            cur_found;
    logic [2:0]      cur_slot;
    logic [1:0]      cur_type;
    logic            more;
    logic            valid;
    logic            hs;
    logic            retire;
    logic            push_req;
    logic            accept;

    assign head_type = mem_type[rd_ptr];
    assign valid     = (count != '0);
    assign hs        = valid && bus.ser_ready;
    // The current symbol is final for its beat when no further non-NULL slot
    // follows; an empty last-marker beat is also final on its only handshake.
    assign retire    = hs && !more;
    assign push_req  = (|bus.me_output_type) || bus.me_last_output;
    assign accept    = push_req && ((count != FULL_CNT) || retire);

    // Locate the next non-NULL slot at or after idx and whether another follows.
    always_comb begin
        cur_found = 1'b0;
        cur_slot  = 3'd0;
        cur_type  = T_NULL;
        more      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if ((3'(i) >= idx) && (head_type[i] != T_NULL)) begin
                if (!cur_found) begin
                    cur_found = 1'b1;
                    cur_slot  = 3'(i);
                    cur_type  = head_type[i];
                end else begin
                    more = 1'b1;
                end
            end
        end
    end

    // Present the head symbol; all data fields are forced to 0 where not meaningful.
    always_comb begin
        bus.ser_valid      = valid;
        bus.ser_type       = valid ? cur_type : T_NULL;
        bus.ser_literal    = (valid && (cur_type == T_LIT)) ? mem_lit[rd_ptr][lidx] : 8'd0;
        bus.ser_ptr_length = (valid && cur_type[1]) ? mem_len[rd_ptr] : '0;
        bus.ser_ptr_offset = (valid && cur_type[1]) ? mem_off[rd_ptr] : '0;
        bus.ser_last       = valid && mem_last[rd_ptr] && !more;
        bus.ser_afull      = (count >= AFULL_CNT);
        bus.ser_overflow   = overflow;
    end

    // Capture an accepted beat at the write pointer.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_type[wr_ptr] <= bus.me_output_type;
            mem_lit[wr_ptr]  <= bus.me_literal;
            mem_len[wr_ptr]  <= bus.me_ptr_length;
            mem_off[wr_ptr]  <= bus.me_ptr_offset;
            mem_last[wr_ptr] <= bus.me_last_output;
        end
    end

    // FIFO pointers, occupancy, slot walk and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            idx      <= 3'd0;
            lidx     <= 2'd0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (retire) begin
                rd_ptr <= rd_ptr + 1'b1;
                idx    <= 3'd0;
                lidx   <= 2'd0;
            end else if (hs) begin
                idx <= cur_slot + 3'd1;
                if (cur_type == T_LIT) begin
                    lidx <= lidx + 2'd1;
                end
            end
            case ({accept, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef CR_LZ77_COMP_SYM_SER_STATS_EN
    logic [31:0] lit_cnt;
    logic [31:0] ptr_cnt;

    assign bus.ser_lit_count = lit_cnt;
    assign bus.ser_ptr_count = ptr_cnt;

    // Saturating handshake counters by symbol class.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lit_cnt <= '0;
            ptr_cnt <= '0;
        end else if (hs) begin
            if ((cur_type == T_LIT) && (lit_cnt != '1)) begin
                lit_cnt <= lit_cnt + 32'd1;
            end
            if (cur_type[1] && (ptr_cnt != '1)) begin
                ptr_cnt <= ptr_cnt + 32'd1;
            end
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_cr_lz77_comp_sym_ser.sv
`default_nettype none
// ============================================================================
// Module      : tb_cr_lz77_comp_sym_ser
// Description : Directed and random stimulus for cr_lz77_comp_sym_ser, checked
//               against a symbol-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cr_lz77_comp_sym_ser;
    localparam logic [1:0] NUL = 2'd0;
    localparam logic [1:0] LIT = 2'd1;
    localparam logic [1:0] PTR = 2'd2;
    localparam logic [1:0] MTF = 2'd3;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;

    cr_lz77_comp_sym_ser_if #(.LEN_W(10)) bus ();

    cr_lz77_comp_sym_ser #(.LEN_W(10), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] typ;
        logic [7:0] lit;
        logic [9:0] len;
        logic [9:0] off;
        logic       last;
        logic       eob;
    } sym_t;

    sym_t  sym_q[$];
    int    occ;
    logic  ovf;
    int    n_checks;
    int    n_fail;
`ifdef CR_LZ77_COMP_SYM_SER_STATS_EN
    logic [31:0] m_lit;
    logic [31:0] m_ptr;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0][1:0] mk(input logic [1:0] s0, input logic [1:0] s1,
                                            input logic [1:0] s2, input logic [1:0] s3,
                                            input logic [1:0] s4);
        logic [4:0][1:0] t;
        t[0] = s0; t[1] = s1; t[2] = s2; t[3] = s3; t[4] = s4;
        return t;
    endfunction

    // One clock cycle: drive a beat, check the presented symbol, advance the model.
    task automatic step(input logic [4:0][1:0] t, input logic [31:0] lits,
                        input logic [9:0] len, input logic [9:0] off,
                        input logic last, input logic rdy);
        sym_t e;
        sym_t b[$];
        logic exp_valid;
        logic retire;
        int   lastnn;
        int   k;
        bus.me_output_type = t;
        bus.me_literal     = lits;
        bus.me_ptr_length  = len;
        bus.me_ptr_offset  = off;
        bus.me_last_output = last;
        bus.ser_ready      = rdy;
        @(negedge clk);
        exp_valid = (sym_q.size() > 0);
        check("ser_valid", 32'(bus.ser_valid), 32'(exp_valid));
        if (exp_valid) begin
            e = sym_q[0];
            check("ser_type", 32'(bus.ser_type), 32'(e.typ));
            check("ser_literal", 32'(bus.ser_literal), 32'(e.lit));
            check("ser_ptr_length", 32'(bus.ser_ptr_length), 32'(e.len));
            check("ser_ptr_offset", 32'(bus.ser_ptr_offset), 32'(e.off));
            check("ser_last", 32'(bus.ser_last), 32'(e.last));
        end
        check("ser_afull", 32'(bus.ser_afull), 32'(occ >= DEPTH - 2));
        check("ser_overflow", 32'(bus.ser_overflow), 32'(ovf));
`ifdef CR_LZ77_COMP_SYM_SER_STATS_EN
        check("ser_lit_count", bus.ser_lit_count, m_lit);
        check("ser_ptr_count", bus.ser_ptr_count, m_ptr);
`endif
        @(posedge clk);
        retire = 1'b0;
        if (exp_valid && rdy) begin
            e = sym_q.pop_front();
`ifdef CR_LZ77_COMP_SYM_SER_STATS_EN
            if (e.typ == LIT) m_lit++;
            if (e.typ == PTR || e.typ == MTF) m_ptr++;
`endif
            if (e.eob) begin
                retire = 1'b1;
                occ--;
            end
        end
        // Expand the beat into its symbol list.
        lastnn = -1;
        for (int s = 0; s < 5; s++) if (t[s] != NUL) lastnn = s;
        k = 0;
        for (int s = 0; s < 5; s++) begin
            if (t[s] != NUL) begin
                e.typ = t[s];
                if (t[s] == LIT) begin
                    e.lit = lits[8*k +: 8];
                    e.len = '0;
                    e.off = '0;
                    k++;
                end else begin
                    e.lit = '0;
                    e.len = len;
                    e.off = off;
                end
                e.eob  = (s == lastnn);
                e.last = (s == lastnn) && last;
                b.push_back(e);
            end
        end
        if (lastnn < 0 && last) begin
            e.typ = NUL; e.lit = '0; e.len = '0; e.off = '0; e.last = 1'b1; e.eob = 1'b1;
            b.push_back(e);
        end
        if (b.size() > 0) begin
            if (occ < DEPTH) begin
                foreach (b[i]) sym_q.push_back(b[i]);
                occ++;
            end else begin
                ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(mk(NUL, NUL, NUL, NUL, NUL), 32'd0, 10'd0, 10'd0, 1'b0, rdy);
    endtask

    task automatic check_reset_outputs();
        check("rst ser_valid", 32'(bus.ser_valid), 32'd0);
        check("rst ser_last", 32'(bus.ser_last), 32'd0);
        check("rst ser_afull", 32'(bus.ser_afull), 32'd0);
        check("rst ser_overflow", 32'(bus.ser_overflow), 32'd0);
        check("rst ser_type", 32'(bus.ser_type), 32'd0);
        check("rst ser_literal", 32'(bus.ser_literal), 32'd0);
        check("rst ser_ptr_length", 32'(bus.ser_ptr_length), 32'd0);
        check("rst ser_ptr_offset", 32'(bus.ser_ptr_offset), 32'd0);
    endtask

    // Asynchronous reset pulse mid-stream; clears the model.
    task automatic pulse_reset();
        bus.me_output_type = '0;
        bus.me_last_output = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        sym_q.delete();
        occ = 0;
        ovf = 1'b0;
`ifdef CR_LZ77_COMP_SYM_SER_STATS_EN
        m_lit = '0;
        m_ptr = '0;
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [4:0][1:0] t;
        int nlit;
        n_checks = 0;
        n_fail   = 0;
        occ      = 0;
        ovf      = 1'b0;
`ifdef CR_LZ77_COMP_SYM_SER_STATS_EN
        m_lit = '0;
        m_ptr = '0;
`endif
        rst = 1'b1;
        bus.me_output_type = '0;
        bus.me_literal     = '0;
        bus.me_ptr_length  = '0;
        bus.me_ptr_offset  = '0;
        bus.me_last_output = 1'b0;
        bus.ser_ready      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two LITs then a PTR, ready held high.
        step(mk(LIT, LIT, PTR, NUL, NUL), 32'h0000_4241, 10'd5, 10'd9, 1'b0, 1'b1);
        repeat (4) idle(1'b1);

        // LIT then MTF with last; ready low for three cycles.
        step(mk(LIT, MTF, NUL, NUL, NUL), 32'h0000_0077, 10'd3, 10'd2, 1'b1, 1'b0);
        repeat (3) idle(1'b0);
        repeat (3) idle(1'b1);

        // Empty end-of-stream marker.
        step(mk(NUL, NUL, NUL, NUL, NUL), 32'd0, 10'd0, 10'd0, 1'b1, 1'b1);
        repeat (2) idle(1'b1);

        // Full FIFO, head retiring while a new beat arrives: accepted, no overflow.
        pulse_reset();
        for (int i = 0; i < DEPTH; i++)
            step(mk(LIT, NUL, NUL, NUL, NUL), 32'(i + 8'h10), 10'd0, 10'd0, 1'b0, 1'b0);
        step(mk(PTR, NUL, NUL, NUL, NUL), 32'd0, 10'd7, 10'd11, 1'b0, 1'b1);
        idle(1'b0);
        repeat (12) idle(1'b1);

        // Nine 4-LIT beats with ready low: afull after six, ninth dropped.
        pulse_reset();
        for (int i = 0; i < 9; i++)
            step(mk(LIT, LIT, LIT, LIT, NUL), $urandom, 10'd0, 10'd0, 1'b0, 1'b0);
        repeat (3) idle(1'b0);
        repeat (40) idle(1'b1);

        // Reset with three queued beats, then a fresh beat at N+1.
        for (int i = 0; i < 3; i++)
            step(mk(LIT, PTR, NUL, NUL, NUL), $urandom, 10'd1, 10'd2, 1'b0, 1'b0);
        pulse_reset();
        step(mk(NUL, MTF, LIT, NUL, NUL), 32'h0000_00aa, 10'd4, 10'd6, 1'b1, 1'b1);
        repeat (3) idle(1'b1);

        // Random beats and backpressure.
        for (int n = 0; n < 600; n++) begin
            t = '0;
            if ($urandom_range(0, 9) >= 3) begin
                nlit = 0;
                for (int s = 0; s < 5; s++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        t[s] = 2'($urandom_range(1, 3));
                        if (t[s] == LIT) begin
                            if (nlit == 4) t[s] = PTR;
                            else nlit++;
                        end
                    end
                end
            end
            step(t, $urandom, 10'($urandom), 10'($urandom),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
        end
        repeat (50) idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
